shifter_sll_seq: RTL and testbench

Multi-cycle 32-bit shift-left-logical unit. It is the left-direction counterpart of the combinational SRL barrel shifter in the ALU datapath.
- Walks the same 1/2/4/8/16 barrel stages, one stage per clock, under a start/busy/done handshake.
- Sits beside the ALU and is selected by the 6-bit function code on Signal.
- Result is registered and held until the next completion.

---
 rtl/shifter_sll_seq_pkg.sv | 21 ++
 rtl/shifter_sll_seq_shift_stage_left.sv | 25 ++
 rtl/shifter_sll_seq.sv | 91 +++++++++
 tb/tb_shifter_sll_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/shifter_sll_seq_pkg.sv
// Shared ALU definitions: function codes, shifter FSM encoding and datapath widths.
package shifter_sll_seq_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STAGE_W = 3;

  // ALU function codes carried on Signal
  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] SLT = 6'b101010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shiftStateE;

endpackage

// File: rtl/shifter_sll_seq_shift_stage_left.sv
// One barrel stage: shifts left by 2^stageIdx with zero fill when enabled.
module shift_stage_left
  import shifter_sll_seq_pkg::*;
(
  input  logic [WIDTH-1:0]   dataIn,
  input  logic               enable,
  input  logic [STAGE_W-1:0] stageIdx,
  output logic [WIDTH-1:0]   dataShifted
);

  logic [WIDTH-1:0] shiftedByStage [SHAMT_W];

  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : gStage
    localparam int S = 2 ** gi;
    assign shiftedByStage[gi] = {dataIn[WIDTH-1-S:0], {S{1'b0}}};
  end

  always_comb begin
    dataShifted = dataIn;
    if (enable && (stageIdx < STAGE_W'(SHAMT_W))) begin
      dataShifted = shiftedByStage[stageIdx];
    end
  end

endmodule

// File: rtl/shifter_sll_seq.sv
// Multi-cycle SLL unit: one barrel stage per clock, fixed five-cycle latency.
module shifter_sll_seq
  import shifter_sll_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  shiftStateE           stateReg, stateNext;
  logic [STAGE_W-1:0]   stageReg, stageNext;
  logic [WIDTH-1:0]     workReg, workNext;
  logic [SHAMT_W-1:0]   amtReg, amtNext;
  logic [5:0]           opReg, opNext;
  logic [WIDTH-1:0]     dataOutReg, dataOutNext;
  logic [WIDTH-1:0]     stageOut;
  logic                 unusedAmtBits;

  // Upper amount bits are architecturally ignored
  assign unusedAmtBits = ^dataB[WIDTH-1:SHAMT_W];

  shift_stage_left uStage (
    .dataIn      (workReg),
    .enable      (amtReg[stageReg]),
    .stageIdx    (stageReg),
    .dataShifted (stageOut)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      stageReg   <= '0;
      workReg    <= '0;
      amtReg     <= '0;
      opReg      <= '0;
      dataOutReg <= '0;
    end else begin
      stateReg   <= stateNext;
      stageReg   <= stageNext;
      workReg    <= workNext;
      amtReg     <= amtNext;
      opReg      <= opNext;
      dataOutReg <= dataOutNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    stageNext   = stageReg;
    workNext    = workReg;
    amtNext     = amtReg;
    opNext      = opReg;
    dataOutNext = dataOutReg;
    case (stateReg)
      IDLE, DONE: begin
        if (start) begin
          workNext  = dataA;
          amtNext   = dataB[SHAMT_W-1:0];
          opNext    = Signal;
          stageNext = '0;
          stateNext = SHIFT;
        end else begin
          stateNext = IDLE;
        end
      end
      SHIFT: begin
        workNext = stageOut;
        // Last stage result goes straight to the output register
        if (stageReg == STAGE_W'(SHAMT_W - 1)) begin
          dataOutNext = (opReg == SLL) ? stageOut : '0;
          stageNext   = '0;
          stateNext   = DONE;
        end else begin
          stageNext = stageReg + STAGE_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign dataOut = dataOutReg;
  assign busy    = (stateReg == SHIFT);
  assign done    = (stateReg == DONE);

endmodule

// File: tb/tb_shifter_sll_seq.sv
// Directed plus random checks of shifter_sll_seq against an arithmetic reference.
module tb_shifter_sll_seq;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  logic [31:0] expOut = '0;

  shifter_sll_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference: left shift as multiplication by a power of two, truncated to 32 bits
  function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] sig);
    logic [63:0] prod;
    longint unsigned scale;
    scale = 64'd1;
    for (int i = 0; i < int'(b % 32); i++) scale = scale * 2;
    prod = 64'(a) * scale;
    return (sig == FN_SLL) ? prod[31:0] : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op; caller is #1 after a rising edge. Optionally disturb inputs while busy.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                       input bit disturb);
    logic [31:0] want;
    want   = refModel(a, b, sig);
    start  = 1'b1;
    dataA  = a;
    dataB  = b;
    Signal = sig;
    @(posedge clk); #1;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_done", 32'(done), 32'd0);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (disturb) begin
        start  = 1'b1;
        dataA  = $urandom;
        dataB  = $urandom;
        Signal = ($urandom_range(0, 1) == 0) ? FN_SLL : 6'($urandom);
      end
      @(posedge clk); #1;
      chk("stage_busy", 32'(busy), 32'd1);
      chk("stage_done", 32'(done), 32'd0);
      chk("stage_hold", dataOut, expOut);
    end
    start = 1'b0;
    @(posedge clk); #1;
    expOut = want;
    chk("cmpl_done", 32'(done), 32'd1);
    chk("cmpl_busy", 32'(busy), 32'd0);
    chk("cmpl_data", dataOut, expOut);
    $display("op a=%h b=%h sig=%b -> out=%h exp=%h", a, b, sig, dataOut, expOut);
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_hold", dataOut, expOut);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", dataOut, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    idleCycle();

    // Basic and boundary amounts
    runOp(32'h0000_0001, 32'd31, FN_SLL, 1'b0);
    chk("t1_value", dataOut, 32'h8000_0000);
    idleCycle();
    runOp(32'h1234_5678, 32'hFFFF_FFE4, FN_SLL, 1'b0);
    chk("t2_value", dataOut, 32'h2345_6780);
    idleCycle();
    runOp(32'h1234_5678, 32'd0, FN_SLL, 1'b0);
    chk("t2_zero", dataOut, 32'h1234_5678);
    idleCycle();
    runOp(32'hFFFF_FFFF, 32'd3, FN_SRL, 1'b0);
    chk("t3_srl", dataOut, 32'h0000_0000);
    idleCycle();

    // Restart attempts and operand changes while busy
    runOp(32'hDEAD_BEEF, 32'd8, FN_SLL, 1'b1);
    chk("t4_value", dataOut, 32'hADBE_EF00);
    idleCycle();

    // Reset mid-operation at stage 2
    start = 1'b1; dataA = 32'hAAAA_AAAA; dataB = 32'd1; Signal = FN_SLL;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    expOut = '0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_out", dataOut, 32'd0);
    // Reset wins over a simultaneous start
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    chk("t5_rststart", 32'(busy), 32'd0);
    idleCycle();
    runOp(32'h0000_000F, 32'd4, FN_SLL, 1'b0);
    chk("t5_value", dataOut, 32'h0000_00F0);

    // Back-to-back issue from the DONE cycle
    runOp(32'h0000_0003, 32'd30, FN_SLL, 1'b0);
    chk("t6_value", dataOut, 32'hC000_0000);
    idleCycle();

    // Randomised operations
    for (int n = 0; n < 24; n++) begin
      logic [5:0] sig;
      case ($urandom_range(0, 3))
        0, 1:    sig = FN_SLL;
        2:       sig = FN_SRL;
        default: sig = 6'($urandom);
      endcase
      runOp($urandom, $urandom, sig, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) idleCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
